// File: rtl/jk_pkg.sv
// JK op encoding shared by the bank arbiter and its cells.
package jk_pkg;

    typedef logic [1:0] jk_op_t;

    localparam jk_op_t JK_HOLD = 2'b00;
    localparam jk_op_t JK_CLR  = 2'b01;
    localparam jk_op_t JK_SET  = 2'b10;
    localparam jk_op_t JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell; q_n is derived from the same register so it is always ~q.
module jk_cell
    import jk_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] op,
    output logic       q,
    output logic       q_n
);

    logic q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            unique case (jk_op_t'(op))
                JK_HOLD: q_d = q_q;
                JK_CLR:  q_d = 1'b0;
                JK_SET:  q_d = 1'b1;
                JK_TGL:  q_d = ~q_q;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    assign q_n = ~q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting one JK op per clock onto a bank of jk_cell instances.
// Optional toggle statistics counter enabled by defining JKARB_STATS_EN.
module jk_bank_arbiter
    import jk_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NBITS = 8,
    parameter int unsigned IW    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [IW*NREQ-1:0]   req_idx,
    output logic [NREQ-1:0]      req_ready,
    output logic [NBITS-1:0]     q,
    output logic [NBITS-1:0]     q_n,
    output logic [NREQ-1:0]      gnt_last,
    output logic                 err
`ifdef JKARB_STATS_EN
    ,
    output logic [15:0]          toggle_cnt
`endif
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    ptr_q, ptr_d, win;
    logic [NREQ-1:0]  grant;
    logic             found;
    jk_op_t           win_op;
    logic [IW-1:0]    win_idx;
    logic             accept, in_range;
    logic [NBITS-1:0] cell_en;
    logic [NREQ-1:0]  gnt_last_q;
    logic             err_q;

    // Scan from the pointer upward, wrapping; first valid requester wins.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[(int'(ptr_q) + i) % NREQ]) begin
                found = 1'b1;
                win   = PW'((int'(ptr_q) + i) % NREQ);
                grant[(int'(ptr_q) + i) % NREQ] = 1'b1;
            end
        end
    end

    assign req_ready = rst ? '0 : grant;
    assign accept    = |req_ready;
    assign win_op    = jk_op_t'(req_op[2*win +: 2]);
    assign win_idx   = req_idx[IW*win +: IW];
    assign in_range  = (32'(win_idx) < NBITS);
    assign ptr_d     = accept ? PW'((int'(win) + 1) % NREQ) : ptr_q;

    for (genvar c = 0; c < NBITS; c++) begin : g_cell
        assign cell_en[c] = accept && in_range && (win_idx == IW'(c));

        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .en  (cell_en[c]),
            .op  (win_op),
            .q   (q[c]),
            .q_n (q_n[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            gnt_last_q <= '0;
            err_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            gnt_last_q <= req_ready;
            err_q      <= accept && !in_range;
        end
    end

    assign gnt_last = gnt_last_q;
    assign err      = err_q;

`ifdef JKARB_STATS_EN
    logic [15:0] tcnt_q, tcnt_d;

    always_comb begin
        tcnt_d = tcnt_q;
        if (accept && in_range && (win_op == JK_TGL) && (tcnt_q != 16'hFFFF)) begin
            tcnt_d = tcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign toggle_cnt = tcnt_q;
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Table-driven bench for jk_bank_arbiter (NBITS=6 so out-of-range indices are reachable).
module tb_jk_bank_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned NBITS = 6;
    localparam int unsigned IW    = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [2*NREQ-1:0]   req_op;
    logic [IW*NREQ-1:0]  req_idx;
    logic [NREQ-1:0]     req_ready;
    logic [NBITS-1:0]    q, q_n;
    logic [NREQ-1:0]     gnt_last;
    logic                err;
`ifdef JKARB_STATS_EN
    logic [15:0]         toggle_cnt;
`endif

    always #5 clk = ~clk;

    jk_bank_arbiter #(
        .NREQ  (NREQ),
        .NBITS (NBITS),
        .IW    (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_idx    (req_idx),
        .req_ready  (req_ready),
        .q          (q),
        .q_n        (q_n),
        .gnt_last   (gnt_last),
        .err        (err)
`ifdef JKARB_STATS_EN
        ,
        .toggle_cnt (toggle_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [7:0]  op;
        logic [11:0] idx;
        logic [3:0]  rdy;
        logic [5:0]  q;
        logic [3:0]  gnt;
        logic        err;
        logic [15:0] tc;
    } vec_t;

    typedef struct {
        logic [5:0]  q;
        logic [3:0]  gnt;
        logic        err;
        logic [15:0] tc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic r, logic [3:0] v, logic [7:0] o, logic [11:0] ix,
                                logic [3:0] rdy, logic [5:0] eq, logic [3:0] g, logic e,
                                logic [15:0] tc);
        vec_t x;
        x.rst = r; x.valid = v; x.op = o; x.idx = ix;
        x.rdy = rdy; x.q = eq; x.gnt = g; x.err = e; x.tc = tc;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int n);
        exp_t       e;
        logic [5:0] qn_exp;
        @(negedge clk);
        rst       = v.rst;
        req_valid = v.valid;
        req_op    = v.op;
        req_idx   = v.idx;
        #1;
        check($sformatf("ready[%0d]", n), 32'(req_ready), 32'(v.rdy));
        e.q = v.q; e.gnt = v.gnt; e.err = v.err; e.tc = v.tc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        qn_exp = ~e.q;
        check($sformatf("q[%0d]", n), 32'(q), 32'(e.q));
        check($sformatf("q_n[%0d]", n), 32'(q_n), 32'(qn_exp));
        check($sformatf("gnt_last[%0d]", n), 32'(gnt_last), 32'(e.gnt));
        check($sformatf("err[%0d]", n), 32'(err), 32'(e.err));
`ifdef JKARB_STATS_EN
        check($sformatf("toggle_cnt[%0d]", n), 32'(toggle_cnt), 32'(e.tc));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic served;
        rst = 1'b1; req_valid = '0; req_op = '0; req_idx = '0;

        // Reset with all requesters valid.
        vecs.push_back(mk(1, 4'hF, {2'b10, 2'b10, 2'b10, 2'b10}, {3'd3, 3'd2, 3'd1, 3'd0},
                          4'h0, 6'h00, 4'h0, 0, 0));
        vecs.push_back(mk(1, 4'hF, {2'b10, 2'b10, 2'b10, 2'b10}, {3'd3, 3'd2, 3'd1, 3'd0},
                          4'h0, 6'h00, 4'h0, 0, 0));
        // Single requester: set, toggle, toggle on cell 3.
        vecs.push_back(mk(0, 4'b0010, {2'b00, 2'b00, 2'b10, 2'b00}, {3'd0, 3'd0, 3'd3, 3'd0},
                          4'b0010, 6'h08, 4'b0010, 0, 0));
        vecs.push_back(mk(0, 4'b0010, {2'b00, 2'b00, 2'b11, 2'b00}, {3'd0, 3'd0, 3'd3, 3'd0},
                          4'b0010, 6'h00, 4'b0010, 0, 1));
        vecs.push_back(mk(0, 4'b0010, {2'b00, 2'b00, 2'b11, 2'b00}, {3'd0, 3'd0, 3'd3, 3'd0},
                          4'b0010, 6'h08, 4'b0010, 0, 2));
        // Hold op from req3 consumes the grant; pointer wraps to 0.
        vecs.push_back(mk(0, 4'b1000, 8'h00, 12'h000, 4'b1000, 6'h08, 4'b1000, 0, 2));
        // Round robin: all valid, order 0,1,2,3,0.
        vecs.push_back(mk(0, 4'hF, 8'hAA, {3'd5, 3'd2, 3'd1, 3'd0}, 4'b0001, 6'h09, 4'b0001, 0, 2));
        vecs.push_back(mk(0, 4'hF, 8'hAA, {3'd5, 3'd2, 3'd1, 3'd0}, 4'b0010, 6'h0B, 4'b0010, 0, 2));
        vecs.push_back(mk(0, 4'hF, 8'hAA, {3'd5, 3'd2, 3'd1, 3'd0}, 4'b0100, 6'h0F, 4'b0100, 0, 2));
        vecs.push_back(mk(0, 4'hF, 8'hAA, {3'd5, 3'd2, 3'd1, 3'd0}, 4'b1000, 6'h2F, 4'b1000, 0, 2));
        vecs.push_back(mk(0, 4'hF, 8'hAA, {3'd5, 3'd2, 3'd1, 3'd0}, 4'b0001, 6'h2F, 4'b0001, 0, 2));
        // Pointer skip: pointer to 2, then only req0/req1 valid.
        vecs.push_back(mk(0, 4'b0010, 8'h00, 12'h000, 4'b0010, 6'h2F, 4'b0010, 0, 2));
        vecs.push_back(mk(0, 4'b0011, {2'b00, 2'b00, 2'b01, 2'b01}, {3'd0, 3'd0, 3'd1, 3'd0},
                          4'b0001, 6'h2E, 4'b0001, 0, 2));
        vecs.push_back(mk(0, 4'b0010, {2'b00, 2'b00, 2'b01, 2'b01}, {3'd0, 3'd0, 3'd1, 3'd0},
                          4'b0010, 6'h2C, 4'b0010, 0, 2));
        vecs.push_back(mk(0, 4'hF, 8'h00, 12'h000, 4'b0100, 6'h2C, 4'b0100, 0, 2));
        // Out-of-range index: accepted, bank unchanged, single-cycle err.
        vecs.push_back(mk(0, 4'b0100, {2'b00, 2'b10, 2'b00, 2'b00}, {3'd0, 3'd7, 3'd0, 3'd0},
                          4'b0100, 6'h2C, 4'b0100, 1, 2));
        vecs.push_back(mk(0, 4'b0000, 8'h00, 12'h000, 4'b0000, 6'h2C, 4'b0000, 0, 2));
        // Reset mid-stream with req3 toggling, then release.
        vecs.push_back(mk(1, 4'b1000, {2'b11, 6'h00}, 12'h000, 4'b0000, 6'h00, 4'b0000, 0, 0));
        vecs.push_back(mk(1, 4'b1000, {2'b11, 6'h00}, 12'h000, 4'b0000, 6'h00, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b1000, {2'b11, 6'h00}, 12'h000, 4'b1000, 6'h01, 4'b1000, 0, 1));
        // Out-of-range toggle is not counted.
        vecs.push_back(mk(0, 4'b0001, {6'h00, 2'b11}, {9'h000, 3'd6}, 4'b0001, 6'h01, 4'b0001, 1, 1));
        // Reset then lowest valid index wins.
        vecs.push_back(mk(1, 4'hF, 8'hFF, 12'h000, 4'b0000, 6'h00, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b1010, {2'b11, 2'b00, 2'b10, 2'b00}, {3'd0, 3'd0, 3'd2, 3'd0},
                          4'b0010, 6'h04, 4'b0010, 0, 0));
        vecs.push_back(mk(0, 4'b1000, {2'b11, 2'b00, 2'b10, 2'b00}, {3'd0, 3'd0, 3'd2, 3'd0},
                          4'b1000, 6'h05, 4'b1000, 0, 1));

        foreach (vecs[i]) apply(vecs[i], i);

        // Dropped request: req2 loses to req0 and then deasserts without error.
        apply(mk(0, 4'b0101, {2'b00, 2'b10, 2'b00, 2'b10}, {3'd0, 3'd3, 3'd0, 3'd1},
                 4'b0001, 6'h07, 4'b0001, 0, 1), 100);
        apply(mk(0, 4'b0000, 8'h00, 12'h000, 4'b0000, 6'h07, 4'b0000, 0, 1), 101);

        // Fairness: with all valid, req3 is served within NREQ cycles; grant stays one-hot.
        served = 1'b0;
        @(negedge clk);
        req_valid = 4'hF; req_op = '0; req_idx = '0;
        for (int c = 0; c < NREQ; c++) begin
            #1;
            check($sformatf("onehot[%0d]", c), 32'($onehot(req_ready)), 32'd1);
            if (req_ready[3]) served = 1'b1;
            @(negedge clk);
        end
        check("fair_req3", 32'(served), 32'd1);
        req_valid = '0;
        @(negedge clk);
        check("q_after_holds", 32'(q), 32'h07);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
